// File: rtl/pipe_mem_pkg.sv
// Shared types and default sizing for the IF/MEM memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_mem_pkg;

   localparam int DEF_AW  = 32;
   localparam int DEF_DW  = 32;
   localparam int DEF_TMO = 255;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_BUSY = 2'd1,
      IF_BUSY  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// Request/ack bus between the arbiter (master) and the single-ported memory (slave).
// Latency: n/a (wires only).
// Backpressure: the master holds Mem_* stable until Mem_Ack or timeout.
interface pipe_mem_arbiter_if
   import pipe_mem_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);
   logic          Mem_Req;
   logic          Mem_We;
   logic [AW-1:0] Mem_Addr;
   logic [DW-1:0] Mem_Wdata;
   logic          Mem_Ack;
   logic [DW-1:0] Mem_Rdata;

   modport master (
      output Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
      input  Mem_Ack, Mem_Rdata
   );

   modport slave (
      input  Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
      output Mem_Ack, Mem_Rdata
   );
endinterface

// File: rtl/pipe_ack_timer.sv
// Counts busy cycles of one memory access and flags expiry on the TMO-th busy cycle.
// Latency: expire is combinational from the count register (asserted in busy cycle TMO).
// Backpressure: none; clr has priority over counting.
module pipe_ack_timer
   import pipe_mem_pkg::*;
#(
   parameter int TMO = DEF_TMO
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clr,
   input  logic run,
   output logic expire
);
   localparam int            CW   = $clog2(TMO + 1);
   localparam logic [CW-1:0] LAST = CW'(TMO - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // the count holds at LAST; the access ends that same cycle anyway
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign expire = run & (cnt_q == LAST);

   // count register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one variable-latency memory between IF and MEM, MEM first, one access in flight.
// Latency: 2 cycles request-to-Stall-low for one access, 4 for IF plus MEM.
// Backpressure: Stall freezes the pipeline until every needed access has completed.
module pipe_mem_arbiter
   import pipe_mem_pkg::*;
#(
   parameter int AW  = DEF_AW,
   parameter int DW  = DEF_DW,
   parameter int TMO = DEF_TMO
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          If_Req,
   input  logic [AW-1:0] If_Addr,
   output logic [DW-1:0] If_Rdata,
   input  logic          M_Req,
   input  logic          M_We,
   input  logic [AW-1:0] M_Addr,
   input  logic [DW-1:0] M_Wdata,
   output logic [DW-1:0] M_Rdata,
   output logic          Stall,
   output logic          Bus_Err,
   pipe_mem_arbiter_if.master mem
);
   arb_state_e    state_q,     state_d;
   logic          mem_req_q,   mem_req_d;
   logic          mem_we_q,    mem_we_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] if_rdata_q,  if_rdata_d;
   logic [DW-1:0] m_rdata_q,   m_rdata_d;
   logic [AW-1:0] if_tag_q,    if_tag_d;
   logic          m_done_q,    m_done_d;
   logic          if_done_q,   if_done_d;
   logic          bus_err_q,   bus_err_d;

   logic          busy;
   logic          ack_evt;
   logic          tmo_evt;
   logic          done_evt;
   logic          tmr_expire;
   logic [DW-1:0] rdata;
   logic          need_m;
   logic          need_if;
   logic          stall;

   assign busy     = (state_q != IDLE);
   // a real ack in the expiry cycle wins over the timeout
   assign ack_evt  = busy & mem.Mem_Ack;
   assign tmo_evt  = busy & ~mem.Mem_Ack & tmr_expire;
   assign done_evt = ack_evt | tmo_evt;
   assign rdata    = ack_evt ? mem.Mem_Rdata : '0;

   // a fetch is satisfied only while the registered instruction matches the current PC
   assign need_m  = M_Req & ~m_done_q;
   assign need_if = If_Req & ~(if_done_q & (if_tag_q == If_Addr));
   assign stall   = need_m | need_if;

   pipe_ack_timer #(
      .TMO (TMO)
   ) u_timer (
      .Clk    (Clk),
      .Rst    (Rst),
      .clr    (~busy | done_evt),
      .run    (busy),
      .expire (tmr_expire)
   );

   // issue/complete FSM plus done-flag bookkeeping
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      m_rdata_d   = m_rdata_q;
      if_tag_d    = if_tag_q;
      m_done_d    = m_done_q;
      if_done_d   = if_done_q;
      bus_err_d   = bus_err_q;

      unique case (state_q)
         IDLE: begin
            if (need_m) begin
               mem_req_d   = 1'b1;
               mem_we_d    = M_We;
               mem_addr_d  = M_Addr;
               mem_wdata_d = M_Wdata;
               state_d     = MEM_BUSY;
            end else if (need_if) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = If_Addr;
               state_d    = IF_BUSY;
            end
         end
         MEM_BUSY: begin
            if (done_evt) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
               m_done_d  = 1'b1;
               if (!mem_we_q) begin
                  m_rdata_d = rdata;
               end
            end
         end
         IF_BUSY: begin
            if (done_evt) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
               // a redirected PC drops the stale word and refetches from IDLE
               if (If_Addr == mem_addr_q) begin
                  if_rdata_d = rdata;
                  if_tag_d   = mem_addr_q;
                  if_done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (tmo_evt) begin
         bus_err_d = 1'b1;
      end

      // pipeline advance: the next instruction starts with no accesses done
      if (!stall) begin
         m_done_d  = 1'b0;
         if_done_d = 1'b0;
      end
   end

   // state and output registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         m_rdata_q   <= '0;
         if_tag_q    <= '0;
         m_done_q    <= 1'b0;
         if_done_q   <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         m_rdata_q   <= m_rdata_d;
         if_tag_q    <= if_tag_d;
         m_done_q    <= m_done_d;
         if_done_q   <= if_done_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign mem.Mem_Req   = mem_req_q;
   assign mem.Mem_We    = mem_we_q;
   assign mem.Mem_Addr  = mem_addr_q;
   assign mem.Mem_Wdata = mem_wdata_q;
   assign If_Rdata      = if_rdata_q;
   assign M_Rdata       = m_rdata_q;
   assign Stall         = stall;
   assign Bus_Err       = bus_err_q;
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter with a latency-programmable memory slave.
// Latency: checks are cycle-exact against hand-derived timing.
// Backpressure: the slave acks after 'lat' busy cycles, or never when lat < 0.
module tb_pipe_mem_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          If_Req;
   logic [AW-1:0] If_Addr;
   logic [DW-1:0] If_Rdata;
   logic          M_Req;
   logic          M_We;
   logic [AW-1:0] M_Addr;
   logic [DW-1:0] M_Wdata;
   logic [DW-1:0] M_Rdata;
   logic          Stall;
   logic          Bus_Err;

   pipe_mem_arbiter_if #(.AW(AW), .DW(DW)) mem_if ();

   pipe_mem_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .If_Req   (If_Req),
      .If_Addr  (If_Addr),
      .If_Rdata (If_Rdata),
      .M_Req    (M_Req),
      .M_We     (M_We),
      .M_Addr   (M_Addr),
      .M_Wdata  (M_Wdata),
      .M_Rdata  (M_Rdata),
      .Stall    (Stall),
      .Bus_Err  (Bus_Err),
      .mem      (mem_if)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_errs   = 0;
   int lat      = 0;

   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] issue_addr_q [$];
   logic        issue_we_q   [$];

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic mid();
      @(negedge Clk);
   endtask

   // memory slave: logs each new request, acks after 'lat' busy cycles
   initial begin
      int  wait_cnt;
      logic prev_req;
      wait_cnt = 0;
      prev_req = 1'b0;
      mem_if.Mem_Ack   = 1'b0;
      mem_if.Mem_Rdata = 32'hDEAD_BEEF;
      forever begin
         step();
         mem_if.Mem_Ack   = 1'b0;
         mem_if.Mem_Rdata = 32'hDEAD_BEEF;
         if (mem_if.Mem_Req === 1'b1 && !prev_req) begin
            issue_addr_q.push_back(mem_if.Mem_Addr);
            issue_we_q.push_back(mem_if.Mem_We);
         end
         prev_req = (mem_if.Mem_Req === 1'b1);
         if (mem_if.Mem_Req === 1'b1) begin
            if (lat >= 0 && wait_cnt >= lat) begin
               mem_if.Mem_Ack = 1'b1;
               if (mem_if.Mem_We) mem_arr[mem_if.Mem_Addr] = mem_if.Mem_Wdata;
               else mem_if.Mem_Rdata = rd(mem_if.Mem_Addr);
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b1; If_Req = 1'b0; If_Addr = '0;
      M_Req = 1'b0; M_We = 1'b0; M_Addr = '0; M_Wdata = '0;
      mem_arr[32'h0]   = 32'h2010_FFFF;
      mem_arr[32'h100] = 32'h1111_0100;
      mem_arr[32'h8]   = 32'h2222_0008;

      // reset state
      repeat (3) step();
      Rst = 1'b0;
      mid();
      check("rst_mem_req", mem_if.Mem_Req, 0);
      check("rst_mem_we", mem_if.Mem_We, 0);
      check("rst_mem_addr", mem_if.Mem_Addr, 0);
      check("rst_mem_wdata", mem_if.Mem_Wdata, 0);
      check("rst_if_rdata", If_Rdata, 0);
      check("rst_m_rdata", M_Rdata, 0);
      check("rst_bus_err", Bus_Err, 0);
      check("rst_stall", Stall, 0);

      // T1: single fetch at 0x0, ack one cycle after request
      lat = 1;
      step(); issue_addr_q.delete(); issue_we_q.delete();
      If_Req = 1'b1; If_Addr = 32'h0;
      mid(); check("t1_c0_stall", Stall, 1); check("t1_c0_req", mem_if.Mem_Req, 0);
      step(); mid();
      check("t1_c1_req", mem_if.Mem_Req, 1); check("t1_c1_addr", mem_if.Mem_Addr, 0);
      check("t1_c1_we", mem_if.Mem_We, 0);
      step(); mid(); check("t1_c2_stall", Stall, 1); check("t1_c2_req", mem_if.Mem_Req, 1);
      step(); mid();
      check("t1_c3_if_rdata", If_Rdata, 32'h2010_FFFF); check("t1_c3_stall", Stall, 0);
      check("t1_c3_req", mem_if.Mem_Req, 0);
      step(); If_Req = 1'b0;
      mid(); check("t1_bubble_stall", Stall, 0);
      step(); mid();
      check("t1_bubble_req", mem_if.Mem_Req, 0); check("t1_hold_if_rdata", If_Rdata, 32'h2010_FFFF);
      check("t1_n_issue", issue_addr_q.size(), 1);

      // T2: lw 0x100 and fetch 0x8 together, zero-latency acks
      lat = 0;
      step(); issue_addr_q.delete(); issue_we_q.delete();
      M_Req = 1'b1; M_We = 1'b0; M_Addr = 32'h100; If_Req = 1'b1; If_Addr = 32'h8;
      mid(); check("t2_c0_stall", Stall, 1);
      step(); mid();
      check("t2_c1_req", mem_if.Mem_Req, 1); check("t2_c1_addr", mem_if.Mem_Addr, 32'h100);
      step(); mid(); check("t2_c2_stall", Stall, 1); check("t2_c2_req", mem_if.Mem_Req, 0);
      step(); mid();
      check("t2_c3_req", mem_if.Mem_Req, 1); check("t2_c3_addr", mem_if.Mem_Addr, 32'h8);
      check("t2_c3_stall", Stall, 1);
      step(); mid();
      check("t2_c4_stall", Stall, 0); check("t2_c4_m_rdata", M_Rdata, 32'h1111_0100);
      check("t2_c4_if_rdata", If_Rdata, 32'h2222_0008);
      check("t2_n_issue", issue_addr_q.size(), 2);
      check("t2_iss0", issue_addr_q[0], 32'h100); check("t2_iss1", issue_addr_q[1], 32'h8);
      step(); M_Req = 1'b0; If_Req = 1'b0;
      mid(); check("t2_c5_m_rdata_hold", M_Rdata, 32'h1111_0100);

      // T3: fetch 0x30 in flight, then sw 0x20 arrives; fetch must not repeat
      lat = 1;
      step(); issue_addr_q.delete(); issue_we_q.delete();
      If_Req = 1'b1; If_Addr = 32'h30;
      mid();
      step(); M_Req = 1'b1; M_We = 1'b1; M_Addr = 32'h20; M_Wdata = 32'hCAFE_0001;
      mid(); check("t3_c1_addr", mem_if.Mem_Addr, 32'h30); check("t3_c1_stall", Stall, 1);
      step(); mid();
      step(); mid();
      check("t3_c3_stall", Stall, 1); check("t3_c3_if_rdata", If_Rdata, 32'hA5A5_0030);
      step(); mid();
      check("t3_c4_req", mem_if.Mem_Req, 1); check("t3_c4_we", mem_if.Mem_We, 1);
      check("t3_c4_addr", mem_if.Mem_Addr, 32'h20); check("t3_c4_wdata", mem_if.Mem_Wdata, 32'hCAFE_0001);
      step(); mid();
      step(); mid();
      check("t3_c6_stall", Stall, 0); check("t3_c6_m_rdata", M_Rdata, 32'h1111_0100);
      check("t3_c6_if_rdata", If_Rdata, 32'hA5A5_0030);
      check("t3_n_issue", issue_addr_q.size(), 2); check("t3_iss1_we", issue_we_q[1], 1);
      check("t3_stored", rd(32'h20), 32'hCAFE_0001);
      step(); M_Req = 1'b0; M_We = 1'b0; If_Req = 1'b0;
      mid();

      // T4: fetch 0x10 redirected to 0x40 before a 3-cycle ack (ack lands on the expiry cycle)
      lat = 3;
      step(); issue_addr_q.delete(); issue_we_q.delete();
      If_Req = 1'b1; If_Addr = 32'h10;
      mid();
      step(); mid(); check("t4_c1_addr", mem_if.Mem_Addr, 32'h10); check("t4_c1_we", mem_if.Mem_We, 0);
      step(); If_Addr = 32'h40;
      mid();
      step(); mid();
      step(); mid(); check("t4_c4_req", mem_if.Mem_Req, 1);
      step(); mid();
      check("t4_c5_stall", Stall, 1); check("t4_c5_req", mem_if.Mem_Req, 0);
      check("t4_c5_if_rdata", If_Rdata, 32'hA5A5_0030); check("t4_c5_bus_err", Bus_Err, 0);
      step(); mid();
      check("t4_c6_req", mem_if.Mem_Req, 1); check("t4_c6_addr", mem_if.Mem_Addr, 32'h40);
      repeat (3) begin step(); mid(); end
      check("t4_c9_stall", Stall, 1);
      step(); mid();
      check("t4_c10_stall", Stall, 0); check("t4_c10_if_rdata", If_Rdata, 32'hA5A5_0040);
      check("t4_c10_bus_err", Bus_Err, 0); check("t4_n_issue", issue_addr_q.size(), 2);
      step(); If_Req = 1'b0;
      mid();

      // T5: load 0x200 never acked -> timeout after TMO busy cycles, then a normal load
      lat = -1;
      step(); M_Req = 1'b1; M_We = 1'b0; M_Addr = 32'h200;
      mid();
      step(); mid(); check("t5_c1_req", mem_if.Mem_Req, 1);
      step(); mid();
      step(); mid();
      step(); mid(); check("t5_c4_req", mem_if.Mem_Req, 1); check("t5_c4_bus_err", Bus_Err, 0);
      step(); mid();
      check("t5_c5_req", mem_if.Mem_Req, 0); check("t5_c5_bus_err", Bus_Err, 1);
      check("t5_c5_m_rdata", M_Rdata, 0); check("t5_c5_stall", Stall, 0);
      step(); lat = 0; M_Addr = 32'h104;
      mid(); check("t5_c6_stall", Stall, 1);
      step(); mid(); check("t5_c7_addr", mem_if.Mem_Addr, 32'h104);
      step(); mid();
      check("t5_c8_stall", Stall, 0); check("t5_c8_m_rdata", M_Rdata, 32'hA5A5_0104);
      check("t5_c8_bus_err", Bus_Err, 1);
      step(); M_Req = 1'b0;
      mid();

      // T6: reset pulsed during MEM_BUSY, then a fresh lw + fetch
      lat = -1;
      step(); M_Req = 1'b1; M_We = 1'b0; M_Addr = 32'h300; If_Req = 1'b1; If_Addr = 32'h50;
      mid();
      step(); mid(); check("t6_c1_addr", mem_if.Mem_Addr, 32'h300);
      step(); Rst = 1'b1;
      mid(); check("t6_c2_req", mem_if.Mem_Req, 1);
      step(); Rst = 1'b0; lat = 0;
      mid();
      check("t6_c3_req", mem_if.Mem_Req, 0); check("t6_c3_addr", mem_if.Mem_Addr, 0);
      check("t6_c3_bus_err", Bus_Err, 0); check("t6_c3_m_rdata", M_Rdata, 0);
      check("t6_c3_if_rdata", If_Rdata, 0); check("t6_c3_stall", Stall, 1);
      step(); mid();
      check("t6_c4_req", mem_if.Mem_Req, 1); check("t6_c4_addr", mem_if.Mem_Addr, 32'h300);
      step(); mid();
      step(); mid(); check("t6_c6_addr", mem_if.Mem_Addr, 32'h50);
      step(); mid();
      check("t6_c7_stall", Stall, 0); check("t6_c7_m_rdata", M_Rdata, 32'hA5A5_0300);
      check("t6_c7_if_rdata", If_Rdata, 32'hA5A5_0050);
      step(); M_Req = 1'b0; If_Req = 1'b0;
      mid();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction fetch (IF) port and its data-memory (MEM, lw/sw) port.
- Serialises the two requesters with MEM priority and drives one Stall output that freezes the whole pipeline until every pending access has completed.
- Replaces the ideal split instruction/data memories. Sits between the IF/MEM stages and the external memory slave.

Parameters:
AW, 32, address width
DW, 32, data width
TMO, 255, max cycles to wait for Mem_Ack before abandoning an access (>=1)

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
If_Req  in  1  IF stage needs the instruction at If_Addr
If_Addr  in  AW  fetch address (PC)
If_Rdata  out  DW  registered fetched instruction
M_Req  in  1  MEM stage holds lw or sw
M_We  in  1  1 = store (Wmem), 0 = load
M_Addr  in  AW  data address
M_Wdata  in  DW  store data
M_Rdata  out  DW  registered load data
Stall  out  1  1 = pipeline must hold all stage registers this cycle
Bus_Err  out  1  sticky; a memory access timed out
Mem_Req  out  1  request to memory, registered
Mem_We  out  1  write enable, registered
Mem_Addr  out  AW  registered
Mem_Wdata  out  DW  registered
Mem_Ack  in  1  one-cycle completion strobe; Mem_Rdata valid in that cycle
Mem_Rdata  in  DW  read data

Behaviour:
- Reset: state IDLE. Mem_Req, Mem_We, Bus_Err = 0. Mem_Addr, Mem_Wdata, If_Rdata, M_Rdata = 0. Done flags and timer cleared.
- Reset mid-access: the access is abandoned; Mem_Req = 0 from the next cycle. The memory slave must tolerate a dropped request.
- State: FSM {IDLE, MEM_BUSY, IF_BUSY}.
- State: sticky flags m_done, if_done.
- State: if_tag (AW), the address fetched into If_Rdata.
- Timeout counter of width clog2(TMO+1).
- Need definitions: need_m = M_Req & ~m_done; need_if = If_Req & ~(if_done & if_tag==If_Addr).
- Stall = need_m | need_if. Stall is combinational from inputs and state.
- IDLE: if need_m, latch M_Addr/M_We/M_Wdata into the Mem_* registers, set Mem_Req = 1, go to MEM_BUSY. Else if need_if, latch If_Addr (We = 0), set Mem_Req = 1, go to IF_BUSY.
- BUSY handshake: Mem_Req and Mem_* stay stable until an ack.
- BUSY, on Mem_Ack: Mem_Req = 0, return to IDLE, counter cleared.
- MEM_BUSY ack: set m_done. If the access was a load, M_Rdata <= Mem_Rdata; a store leaves M_Rdata unchanged.
- IF_BUSY ack with If_Addr == Mem_Addr: If_Rdata <= Mem_Rdata, if_tag <= Mem_Addr, set if_done.
- IF_BUSY ack with If_Addr != Mem_Addr (PC redirected by branch/jump): discard the data; if_done stays 0, so the fetch is re-issued from IDLE.
- Minimum latency: request seen -> Mem_Req next cycle -> ack at earliest the same cycle -> data registered -> Stall low. That is 2 cycles for one access and 4 for IF plus MEM.
- Exactly one memory access is in flight at any time. IDLE always spends one cycle between accesses.
- Advance: an edge with Stall == 0 is a pipeline advance. At that edge m_done and if_done clear.
- After an advance, If_Rdata and M_Rdata keep their values until their next ack.
- If_Req = 0 and M_Req = 0 (bubble): Stall = 0; nothing is issued.
- Timeout: the counter runs while BUSY. On reaching TMO without an ack, treat it as an ack with Mem_Rdata = 0 and set Bus_Err (sticky until Rst).
- An ack arriving in the same cycle as the timeout takes precedence; Bus_Err is not set.

Decomposition:
- Package pipe_mem_pkg holds: state enum (IDLE=2'd0, MEM_BUSY=2'd1, IF_BUSY=2'd2) and default AW/DW/TMO constants.
- One sub-module is natural: pipe_ack_timer (load/clear, count, expiry pulse at TMO).

Test Plan:
- If_Req=1, If_Addr=0x0, M_Req=0, memory acks 1 cycle after Mem_Req with 0x2010FFFF -> Mem_Req high at cycle 1, ack at cycle 2, If_Rdata=0x2010FFFF and Stall=0 at cycle 3.
- lw M_Addr=0x100 and If_Addr=0x8 in the same cycle -> Mem_Addr sequence 0x100 then 0x8. Stall stays 1 until both are done. M_Rdata and If_Rdata both hold correct data in the single Stall=0 cycle.
- sw M_We=1, M_Addr=0x20, M_Wdata=0xCAFE0001 -> Mem_We=1, Mem_Wdata=0xCAFE0001, M_Rdata unchanged, if_done preserved across the store.
- IF_BUSY on 0x10, If_Addr changes to 0x40 before a 3-cycle-latency ack -> 0x10 data discarded, second Mem_Req with Mem_Addr=0x40, If_Rdata = data at 0x40.
- TMO=4, Mem_Ack held 0 -> Mem_Req drops after 4 busy cycles, Bus_Err=1 (stays 1), M_Rdata=0, Stall released. A subsequent normal access succeeds.
- Rst pulsed during MEM_BUSY -> next cycle Mem_Req=0, all outputs at reset values, Stall = M_Req | If_Req, and a fresh access starts from IDLE.
